// File: rtl/lc3b_types.sv
// Shared LC-3b widths, opcode constants and MEM-stage helpers.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [3:0]  lc3b_opcode;

    localparam lc3b_opcode op_br   = 4'b0000;
    localparam lc3b_opcode op_add  = 4'b0001;
    localparam lc3b_opcode op_ldb  = 4'b0010;
    localparam lc3b_opcode op_stb  = 4'b0011;
    localparam lc3b_opcode op_jsr  = 4'b0100;
    localparam lc3b_opcode op_and  = 4'b0101;
    localparam lc3b_opcode op_ldr  = 4'b0110;
    localparam lc3b_opcode op_str  = 4'b0111;
    localparam lc3b_opcode op_rti  = 4'b1000;
    localparam lc3b_opcode op_not  = 4'b1001;
    localparam lc3b_opcode op_ldi  = 4'b1010;
    localparam lc3b_opcode op_sti  = 4'b1011;
    localparam lc3b_opcode op_jmp  = 4'b1100;
    localparam lc3b_opcode op_shf  = 4'b1101;
    localparam lc3b_opcode op_lea  = 4'b1110;
    localparam lc3b_opcode op_trap = 4'b1111;

    typedef enum logic [1:0] {
        S_ISSUE    = 2'd0,
        S_INDIRECT = 2'd1,
        S_DONE     = 2'd2
    } mem_state_e;

    // Ops whose first access is a read (STI fetches its pointer first).
    function automatic logic is_mem_read(lc3b_opcode op);
        return (op == op_ldr) || (op == op_ldb) || (op == op_trap) ||
               (op == op_ldi) || (op == op_sti);
    endfunction

    function automatic logic is_mem_write(lc3b_opcode op);
        return (op == op_str) || (op == op_stb) || (op == op_sti);
    endfunction

    function automatic logic is_byte_op(lc3b_opcode op);
        return (op == op_ldb) || (op == op_stb);
    endfunction

    function automatic logic is_indirect(lc3b_opcode op);
        return (op == op_ldi) || (op == op_sti);
    endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering: byte enables, STB data replication, LDB sign extension.
module mem_byte_align
    import lc3b_types::*;
(
    input  lc3b_opcode  opcode,
    input  logic        addr_lsb,
    input  lc3b_word    store_data,
    input  lc3b_word    rdata,
    output logic [1:0]  byte_enable,
    output lc3b_word    wdata,
    output lc3b_word    load_word
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel    = addr_lsb ? rdata[15:8] : rdata[7:0];
        byte_enable = 2'b11;
        wdata       = store_data;
        load_word   = rdata;
        if (is_byte_op(opcode)) begin
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
            wdata       = {store_data[7:0], store_data[7:0]};
            load_word   = {{8{byte_sel[7]}}, byte_sel};
        end
    end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage data-cache access unit: issues LDR/LDB/LDI/TRAP/STR/STB/STI requests,
// holds the indirect pointer and presents the loaded word to MEM/WB.
module mem_stage_access
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  lc3b_opcode  opcode,
    input  lc3b_word    ex_addr,
    input  lc3b_word    store_data,
    input  logic        advance,
    input  logic        ldi_addr_register_load,
    input  logic        memaddrmux_sel,
    input  logic        sti_WE,
    input  lc3b_word    dmem_rdata,
    input  logic        dmem_resp,
    output logic        dmem_read,
    output logic        dmem_write,
    output lc3b_word    dmem_address,
    output lc3b_word    dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        mem_resp,
    output lc3b_word    load_data,
    output logic        load_data_valid
);

    mem_state_e state_q, state_d;
    lc3b_word   indirect_q, indirect_d;
    lc3b_word   load_q, load_d;
    logic       valid_q, valid_d;
    lc3b_word   sel_addr, load_word;
    logic       rd_req, wr_req, mem_op;

    mem_byte_align u_align (
        .opcode      (opcode),
        .addr_lsb    (sel_addr[0]),
        .store_data  (store_data),
        .rdata       (dmem_rdata),
        .byte_enable (dmem_byte_enable),
        .wdata       (dmem_wdata),
        .load_word   (load_word)
    );

    always_comb begin
        mem_op   = is_mem_read(opcode) || is_mem_write(opcode);
        sel_addr = (state_q == S_INDIRECT && memaddrmux_sel) ? {indirect_q[15:1], 1'b0} : ex_addr;
        dmem_address = is_byte_op(opcode) ? sel_addr : {sel_addr[15:1], 1'b0};
        rd_req = 1'b0;
        wr_req = 1'b0;
        case (state_q)
            S_ISSUE: begin
                rd_req = is_mem_read(opcode);
                wr_req = ((opcode == op_str) || (opcode == op_stb)) && sti_WE;
            end
            S_INDIRECT: begin
                rd_req = (opcode == op_ldi);
                wr_req = (opcode == op_sti) && sti_WE;
            end
            default: ;
        endcase
        // Reset kills the request combinationally so an in-flight access is abandoned.
        dmem_read  = rd_req && !reset;
        dmem_write = wr_req && !reset;
        mem_resp   = dmem_resp && (state_q != S_DONE) && !reset;
    end

    always_comb begin
        state_d    = state_q;
        indirect_d = indirect_q;
        load_d     = load_q;
        valid_d    = valid_q;
        case (state_q)
            S_ISSUE: begin
                if (mem_op && dmem_resp) begin
                    if (is_indirect(opcode)) begin
                        if (ldi_addr_register_load) indirect_d = dmem_rdata;
                        state_d = S_INDIRECT;
                    end else begin
                        if (is_mem_read(opcode)) load_d = load_word;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_INDIRECT: begin
                if (dmem_resp) begin
                    if (opcode == op_ldi) load_d = load_word;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (advance) begin
                    valid_d = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_ISSUE;
            indirect_q <= '0;
            load_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            indirect_q <= indirect_d;
            load_q     <= load_d;
            valid_q    <= valid_d;
        end
    end

    assign load_data       = load_q;
    assign load_data_valid = valid_q;

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench: the bench plays cache and LDI/STI controller, and a
// transaction-level model predicts every request, response and loaded value.
module tb_mem_stage_access;
    import lc3b_types::*;

    logic       clk = 1'b0;
    logic       reset;
    lc3b_opcode opcode;
    lc3b_word   ex_addr, store_data, dmem_rdata;
    logic       advance, ldi_addr_register_load, memaddrmux_sel, sti_WE, dmem_resp;
    logic       dmem_read, dmem_write, mem_resp, load_data_valid;
    lc3b_word   dmem_address, dmem_wdata, load_data;
    logic [1:0] dmem_byte_enable;

    int       checks = 0, errors = 0;
    lc3b_word exp_ld = '0;
    int       resp_cnt;

    mem_stage_access dut (
        .clk(clk), .reset(reset), .opcode(opcode), .ex_addr(ex_addr),
        .store_data(store_data), .advance(advance),
        .ldi_addr_register_load(ldi_addr_register_load),
        .memaddrmux_sel(memaddrmux_sel), .sti_WE(sti_WE),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable), .mem_resp(mem_resp),
        .load_data(load_data), .load_data_valid(load_data_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit byte_op(lc3b_opcode op);
        return (op == op_ldb) || (op == op_stb);
    endfunction

    function automatic lc3b_word m_addr(lc3b_opcode op, int ph, lc3b_word a, lc3b_word ptr);
        if (ph == 1) return ptr & 16'hFFFE;
        return byte_op(op) ? a : (a & 16'hFFFE);
    endfunction

    function automatic logic [1:0] m_be(lc3b_opcode op, lc3b_word a);
        if (!byte_op(op)) return 2'b11;
        return (a % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic lc3b_word m_wdata(lc3b_opcode op, lc3b_word sd);
        if (op == op_stb) return (sd % 256) * 257;
        return sd;
    endfunction

    function automatic lc3b_word m_sext_byte(lc3b_word a, lc3b_word r);
        int v;
        v = (a % 2 == 1) ? int'(r) / 256 : int'(r) % 256;
        if (v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    // One instruction through the unit: issue, optional indirect access, DONE, advance.
    task automatic txn(input lc3b_opcode op, input lc3b_word a, input lc3b_word sd,
                       input lc3b_word r1, input lc3b_word r2, input int lat1, input int lat2);
        int  nph, lat;
        bit  ind, er, ew;
        ind = (op == op_ldi) || (op == op_sti);
        nph = ind ? 2 : ((op == op_ldr || op == op_ldb || op == op_trap ||
                          op == op_str || op == op_stb) ? 1 : 0);
        resp_cnt = 0;
        if (nph == 0) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                opcode = op; ex_addr = a; store_data = sd; dmem_resp = 1'b0;
                ldi_addr_register_load = 1'b0; memaddrmux_sel = 1'b0; sti_WE = 1'b1;
                advance = 1'($urandom_range(0, 1));
                #1;
                chk("nm_rd", 32'(dmem_read), 0);
                chk("nm_wr", 32'(dmem_write), 0);
                chk("nm_vld", 32'(load_data_valid), 0);
            end
            return;
        end
        for (int p = 0; p < nph; p++) begin
            lat = (p == 0) ? lat1 : lat2;
            er  = (p == 0) ? !(op == op_str || op == op_stb) : (op == op_ldi);
            ew  = (p == 0) ? (op == op_str || op == op_stb) : (op == op_sti);
            for (int i = 0; i <= lat; i++) begin
                @(negedge clk);
                opcode = op; ex_addr = a; store_data = sd;
                ldi_addr_register_load = ind && (p == 0);
                memaddrmux_sel = (p == 1);
                sti_WE = !(op == op_sti && p == 0);
                dmem_resp  = (i == lat);
                dmem_rdata = (i == lat) ? ((p == 0) ? r1 : r2) : 16'($urandom);
                advance    = 1'($urandom_range(0, 1));
                #1;
                chk("req_rd", 32'(dmem_read), 32'(er));
                chk("req_wr", 32'(dmem_write), 32'(ew));
                chk("req_addr", 32'(dmem_address), 32'(m_addr(op, p, a, r1)));
                chk("req_be", 32'(dmem_byte_enable), 32'(m_be(op, (p == 1) ? r1 & 16'hFFFE : a)));
                if (ew) chk("req_wdata", 32'(dmem_wdata), 32'(m_wdata(op, sd)));
                chk("req_resp", 32'(mem_resp), 32'(dmem_resp));
                chk("req_vld", 32'(load_data_valid), 0);
                if (mem_resp) resp_cnt++;
            end
        end
        if (op == op_ldr || op == op_trap) exp_ld = r1;
        else if (op == op_ldb)             exp_ld = m_sext_byte(a, r1);
        else if (op == op_ldi)             exp_ld = r2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            dmem_resp = 1'($urandom_range(0, 1)); advance = 1'b0;
            ldi_addr_register_load = 1'b0; memaddrmux_sel = 1'b0; sti_WE = 1'b1;
            #1;
            chk("done_rd", 32'(dmem_read), 0);
            chk("done_wr", 32'(dmem_write), 0);
            chk("done_resp", 32'(mem_resp), 0);
            chk("done_vld", 32'(load_data_valid), 1);
            chk("done_data", 32'(load_data), 32'(exp_ld));
        end
        chk("resp_pulses", 32'(resp_cnt), 32'(nph));
        @(negedge clk); dmem_resp = 1'b0; advance = 1'b1;
        @(negedge clk); advance = 1'b0;
        #1;
        chk("adv_vld", 32'(load_data_valid), 0);
        chk("adv_data", 32'(load_data), 32'(exp_ld));
    endtask

    initial begin
        reset = 1'b1; opcode = op_br; ex_addr = '0; store_data = '0; advance = 1'b0;
        ldi_addr_register_load = 1'b0; memaddrmux_sel = 1'b0; sti_WE = 1'b1;
        dmem_rdata = '0; dmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vld", 32'(load_data_valid), 0);
        chk("rst_data", 32'(load_data), 0);
        chk("rst_rd", 32'(dmem_read), 0);
        @(negedge clk); reset = 1'b0;

        txn(op_ldr, 16'h3004, 16'h0, 16'hBEEF, 16'h0, 3, 0);
        chk("ldr_const", 32'(load_data), 32'h0000BEEF);
        txn(op_ldb, 16'h2001, 16'h0, 16'h80AA, 16'h0, 1, 0);
        chk("ldb_hi_const", 32'(load_data), 32'h0000FF80);
        txn(op_ldb, 16'h2000, 16'h0, 16'h80AA, 16'h0, 0, 0);
        chk("ldb_lo_const", 32'(load_data), 32'h0000FFAA);
        txn(op_stb, 16'h1003, 16'h1234, 16'h5555, 16'h0, 2, 0);
        chk("stb_keeps_data", 32'(load_data), 32'h0000FFAA);
        txn(op_ldi, 16'h4000, 16'h0, 16'h5002, 16'h0777, 2, 1);
        chk("ldi_const", 32'(load_data), 32'h00000777);
        txn(op_sti, 16'h6000, 16'hCAFE, 16'h7004, 16'h0, 1, 2);

        // Reset one cycle before the response: request drops, then re-issues.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opcode = op_ldr; ex_addr = 16'h3004; dmem_resp = 1'b0; advance = 1'b0;
            if (i == 2) begin reset = 1'b1; dmem_resp = 1'b1; end
            #1;
            chk("mid_rd", 32'(dmem_read), (i == 2) ? 0 : 1);
            chk("mid_wr", 32'(dmem_write), 0);
            chk("mid_resp", 32'(mem_resp), 0);
        end
        chk("mid_vld", 32'(load_data_valid), 0);
        chk("mid_data", 32'(load_data), 0);
        exp_ld = '0;
        @(negedge clk); reset = 1'b0; dmem_resp = 1'b0;
        #1;
        chk("reissue_rd", 32'(dmem_read), 1);
        chk("reissue_addr", 32'(dmem_address), 32'h3004);
        txn(op_ldr, 16'h3004, 16'h0, 16'h1357, 16'h0, 1, 0);

        // Reset while parked in DONE clears the latches and returns to ISSUE.
        @(negedge clk); opcode = op_trap; ex_addr = 16'h0041; dmem_rdata = 16'hA5A5; dmem_resp = 1'b1;
        @(negedge clk); dmem_resp = 1'b0;
        #1;
        chk("pre_vld", 32'(load_data_valid), 1);
        chk("pre_data", 32'(load_data), 32'h0000A5A5);
        @(negedge clk); reset = 1'b1;
        #1;
        chk("dn_rst_vld", 32'(load_data_valid), 0);
        chk("dn_rst_data", 32'(load_data), 0);
        @(negedge clk); reset = 1'b0;
        #1;
        chk("dn_rst_issue", 32'(dmem_read), 1);
        exp_ld = '0;

        for (int n = 0; n < 150; n++) begin
            txn(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_access.md
Name: mem_stage_access

Overview:
- MEM-stage data-memory access unit of the LC-3b pipeline, directly downstream of the LDI/STI sequencing controller.
- It consumes that controller's register-load, address-mux and store-enable strobes and drives the data-cache request.
- It returns the cache response to the controller.
- It holds the indirect-address register, aligns byte loads and stores, and presents the loaded word to MEM/WB.
- It suppresses re-issue while the pipeline is stalled after the access has completed.

Parameters:
- None. All widths are fixed by lc3b_types: lc3b_word is 16 bits, lc3b_opcode is 4 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- opcode  in  4  MEM-stage opcode (lc3b_opcode).
- ex_addr  in  16  effective address computed in EX.
- store_data  in  16  source-register value for ST/STR/STB/STI.
- advance  in  1  pipeline registers load at this edge (global proceed).
- ldi_addr_register_load  in  1  controller: capture first-access data as the indirect address.
- memaddrmux_sel  in  1  controller: 0 selects ex_addr, 1 selects the indirect register.
- sti_WE  in  1  controller: write permitted (0 during the STI pointer fetch).
- dmem_rdata  in  16  cache read data.
- dmem_resp  in  1  cache access complete.
- dmem_read  out  1  cache read request.
- dmem_write  out  1  cache write request.
- dmem_address  out  16  cache address.
- dmem_wdata  out  16  cache write data.
- dmem_byte_enable  out  2  cache byte enables.
- mem_resp  out  1  response to the controller.
- load_data  out  16  loaded value to MEM/WB.
- load_data_valid  out  1  load_data holds this instruction's result.

Behaviour:
- Memory ops: LDR, LDB, LDI, TRAP, STR, STB, STI.
  - Reads: LDR, LDB, TRAP, and the first access of LDI and STI.
  - Writes: STR, STB, and the second access of STI.
- FSM states: ISSUE, INDIRECT, DONE. Reset state is ISSUE.
- ISSUE state:
  - Non-memory opcode: no request is issued and the FSM stays in ISSUE.
  - Memory opcode: request to address ex_addr.
    - dmem_read = op is a read.
    - dmem_write = (STR or STB) and sti_WE.
  - On dmem_resp for LDI/STI: indirect_reg <= dmem_rdata if ldi_addr_register_load, then go to INDIRECT.
  - On dmem_resp for any other memory op: latch load data, go to DONE.
- INDIRECT state:
  - Address is indirect_reg with bit0 forced to 0, taken when memaddrmux_sel = 1.
  - LDI issues a read. STI issues a write of store_data, gated by sti_WE.
  - On dmem_resp: latch load data (LDI only), then go to DONE.
- DONE state:
  - No request is driven. mem_resp = 0. load_data is held.
  - On advance: go to ISSUE and clear load_data_valid.
- advance seen in ISSUE or INDIRECT while a request is outstanding is ignored. The request is held.
- Request hold rule: read, write, address, wdata and byte_enable stay stable from assertion until the cycle dmem_resp is sampled high. Requests are never dropped early.
- mem_resp = dmem_resp when state is not DONE, else 0. It is combinational and has zero latency.
- Address: dmem_address = selected address, with bit0 cleared for word ops. For LDB/STB, bit0 is passed through.
- Byte enables:
  - Word ops: 2'b11.
  - Byte ops: 2'b10 when addr[0] = 1, else 2'b01.
- STB wdata = {store_data[7:0], store_data[7:0]}. Word stores use store_data unchanged.
- Load data latching:
  - LDB: load_data = sign-extended selected byte (addr[0] = 1 selects [15:8]). Latched on resp.
  - LDR, LDI (second access), TRAP: full word. Latched on resp.
  - load_data_valid is set on the latching edge.
  - Stores do not modify load_data. load_data_valid still rises on completion, meaning done.
- Reset:
  - dmem_read, dmem_write and mem_resp are forced to 0 combinationally while reset is high, including mid-access. A pending response is discarded.
  - Reset values: indirect_reg = 0, load_data = 0, load_data_valid = 0, state = ISSUE.
- A response arriving in the same cycle as advance from ISSUE takes the ISSUE -> DONE/INDIRECT transition. advance is honoured only in DONE.

Decomposition:
- Shared package lc3b_types holds lc3b_word, lc3b_opcode and the op_* constants.
- Add the helpers is_mem_read(op), is_mem_write(op) and is_byte_op(op) there.
- A combinational sub-module mem_byte_align (byte enables, STB data replication, LDB sign-extend) is natural.
- The FSM, indirect register and latches stay at top level.

Test Plan:
- LDR, ex_addr 0x3004, rdata 0xBEEF, resp after 3 cycles:
  - dmem_read is held with address 0x3004 and byte_enable 2'b11.
  - load_data = 0xBEEF. Read drops in DONE while advance = 0.
- LDB with ex_addr 0x2001 and rdata 0x80AA -> load_data 0xFF80, byte_enable 2'b10. LDB with ex_addr 0x2000 -> load_data 0xFFAA.
- STB, ex_addr 0x1003, store_data 0x1234 -> dmem_write, wdata 0x3434, byte_enable 2'b10, address 0x1003.
- LDI, ex_addr 0x4000:
  - First resp returns 0x5002 and the FSM moves to INDIRECT.
  - Second read goes to 0x5002. rdata 0x0777 -> load_data 0x0777.
  - Exactly two mem_resp pulses.
- STI with sti_WE low on the first access and store_data 0xCAFE:
  - The first access is a read of ex_addr.
  - The second access writes 0xCAFE to the pointer address.
  - No write is ever seen on the first address.
- Reset asserted mid-LDR (in the cycle before resp) -> read/write drop the same cycle, load_data_valid = 0, state returns to ISSUE. After release, the LDR re-issues.
